// File: rtl/grayscale_pipe.sv
// grayscale_pipe: two-stage RGB-to-luma converter with valid/ready
// flow control, rounding, saturation and a per-line beat counter.
module grayscale_pipe #(
  parameter int NUM_PIXELS = 4,
  parameter int CW         = 8,
  parameter int LINE_BEATS = 160,
  parameter int WR         = 77,
  parameter int WG         = 150,
  parameter int WB         = 29
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_PIXELS*3*CW-1:0] in_pixels,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_PIXELS*CW-1:0]   out_gray,
  output logic                       out_last,
  output logic                       line_done
);

  localparam int PW   = 2 * CW;
  localparam int SW   = 2 * CW + 2;
  localparam int CNTW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(LINE_BEATS - 1);
  localparam logic [CW-1:0]   GMAX = '1;

  typedef logic [NUM_PIXELS-1:0][PW-1:0] prod_t;

  logic            s1_valid_q;
  logic            s1_pass_q;
  prod_t           s1_pr_q, s1_pg_q, s1_pb_q;
  prod_t           pr_d, pg_d, pb_d;
  logic            pass_d;
  logic [PW-1:0]   wr_w, wg_w, wb_w;

  logic                     out_valid_q;
  logic [NUM_PIXELS*CW-1:0] out_gray_q, gray_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic                     line_done_q;

  logic out_xfer, s2_adv, accept, last_xfer;

  assign out_xfer  = out_valid_q && out_ready;
  assign s2_adv    = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_adv;
  assign accept    = in_valid && in_ready;
  assign last_xfer = out_xfer && (cnt_q == LAST);
  assign cnt_d     = last_xfer ? '0 : cnt_q + CNTW'(1);

  assign out_valid = out_valid_q;
  assign out_gray  = out_gray_q;
  assign out_last  = out_valid_q && (cnt_q == LAST);
  assign line_done = line_done_q;

  // Mode 3 falls back to the weighted coefficients.
  always_comb begin
    pass_d = 1'b0;
    wr_w   = PW'(WR);
    wg_w   = PW'(WG);
    wb_w   = PW'(WB);
    unique case (1'b1)
      (mode == 2'd1): begin
        wr_w = PW'(85);
        wg_w = PW'(86);
        wb_w = PW'(85);
      end
      (mode == 2'd2): pass_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pr_d = '0;
    pg_d = '0;
    pb_d = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (pass_d) begin
        pg_d[i] = PW'(in_pixels[i*3*CW+CW +: CW]);
      end else begin
        pr_d[i] = PW'(in_pixels[i*3*CW+2*CW +: CW]) * wr_w;
        pg_d[i] = PW'(in_pixels[i*3*CW+CW +: CW]) * wg_w;
        pb_d[i] = PW'(in_pixels[i*3*CW +: CW]) * wb_w;
      end
    end
  end

  always_comb begin
    logic [SW-1:0] sum;
    logic [SW-1:0] shr;
    gray_d = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      sum = SW'(s1_pr_q[i]) + SW'(s1_pg_q[i]) + SW'(s1_pb_q[i]) + SW'(128);
      shr = sum >> 8;
      if (s1_pass_q)
        gray_d[i*CW +: CW] = s1_pg_q[i][CW-1:0];
      else if (|shr[SW-1:CW])
        gray_d[i*CW +: CW] = GMAX;
      else
        gray_d[i*CW +: CW] = shr[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pass_q <= pass_d;
      s1_pr_q   <= pr_d;
      s1_pg_q   <= pg_d;
      s1_pb_q   <= pb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_gray_q  <= '0;
      cnt_q       <= '0;
      line_done_q <= 1'b0;
    end else begin
      if (accept)      s1_valid_q <= 1'b1;
      else if (s2_adv) s1_valid_q <= 1'b0;
      if (s2_adv)        out_valid_q <= 1'b1;
      else if (out_xfer) out_valid_q <= 1'b0;
      if (s2_adv) out_gray_q <= gray_d;
      if (out_xfer) cnt_q <= cnt_d;
      line_done_q <= last_xfer;
    end
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// tb_grayscale_pipe: random and directed stimulus checked against a
// queue-based behavioural model of the luma pipeline.
module tb_grayscale_pipe;
  localparam int NP = 4;
  localparam int CW = 8;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [NP*3*CW-1:0] in_pixels = '0;
  logic [1:0] mode = 2'd0;

  logic in_ready, out_valid, out_last, line_done;
  logic [NP*CW-1:0] out_gray;
  logic s_in_ready, s_out_valid, s_out_last, s_line_done;
  logic [NP*CW-1:0] s_out_gray;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grayscale_pipe #(.NUM_PIXELS(NP), .CW(CW), .LINE_BEATS(LB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixels(in_pixels), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_gray(out_gray), .out_last(out_last),
    .line_done(line_done)
  );

  grayscale_pipe #(.NUM_PIXELS(NP), .CW(CW), .WR(128), .WG(128), .WB(128)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pixels(in_pixels), .mode(mode), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_gray(s_out_gray), .out_last(s_out_last),
    .line_done(s_line_done)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] gray1(logic [23:0] p, logic [1:0] md);
    int r, g, b, v;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    if (md == 2'd2) return CW'(g);
    if (md == 2'd1) v = (r * 85 + g * 86 + b * 85 + 128) / 256;
    else            v = (r * 77 + g * 150 + b * 29 + 128) / 256;
    return (v > 255) ? 8'd255 : CW'(v);
  endfunction

  function automatic logic [NP*CW-1:0] gray_beat(logic [NP*3*CW-1:0] px,
                                                 logic [1:0] md);
    logic [NP*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*CW +: CW] = gray1(px[i*24 +: 24], md);
    return r;
  endfunction

  typedef struct {
    logic [NP*CW-1:0] g;
    int               a;
  } exp_t;

  exp_t q[$];
  int   ecnt = 0;
  int   mcount = 0;
  logic ld_pend = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_last = 1'b0;
  logic [NP*CW-1:0] prev_gray = '0;
  logic exp_v, exp_rdy, xfer;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Model: a beat accepted at edge A is visible after edge A+1 once all
  // older beats have left; at most two beats are ever in flight.
  always @(negedge clk) begin
    exp_v   = (q.size() > 0) && (ecnt >= q[0].a + 1);
    exp_rdy = (q.size() < 2) || (exp_v && out_ready);
    chk("out_valid", out_valid, exp_v);
    chk("in_ready", in_ready, exp_rdy);
    chk("line_done", line_done, ld_pend);
    if (exp_v) begin
      chk("out_gray", out_gray, q[0].g);
      chk("out_last", out_last, mcount == LB - 1);
    end
    if (prev_stall) begin
      chk("stall_gray", out_gray, prev_gray);
      chk("stall_last", out_last, prev_last);
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_gray  = out_gray;
    prev_last  = out_last;
    if (rst) begin
      q.delete();
      mcount     = 0;
      ld_pend    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      xfer    = exp_v && out_ready;
      ld_pend = xfer && (mcount == LB - 1);
      if (xfer) begin
        void'(q.pop_front());
        mcount = (mcount + 1) % LB;
      end
      if (in_valid && exp_rdy)
        q.push_back('{g: gray_beat(in_pixels, mode), a: ecnt + 1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sweep_e[4] = '{114, 68, 193, 114};
  int bp_pat[4]  = '{1, 0, 0, 1};
  int sent, blocked, nl, nd, k, idx;
  logic [7:0] ev;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gray", out_gray, 0);
    chk("rst_line_done", line_done, 0);
    tick();
    chk("rst_in_ready", in_ready, 1);

    chk("model_m0", gray1(24'h01C109, 2'd0), 114);
    chk("model_m1", gray1(24'h01C109, 2'd1), 68);
    chk("model_m2", gray1(24'h01C109, 2'd2), 193);
    chk("model_white", gray1(24'hFFFFFF, 2'd0), 255);

    in_pixels = {24'hFFFFFF, 24'h01C109, 24'h01C109, 24'h01C109};
    mode = 2'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_cycle1", out_valid, 0);
    tick();
    chk("lat_cycle2", out_valid, 1);
    chk("m0_gray", out_gray, {8'd255, 8'd114, 8'd114, 8'd114});
    tick();

    for (int m = 0; m < 4; m++) begin
      in_pixels = {24'h0, 24'h01C109, 24'h0, 24'h01C109};
      mode = 2'(m);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      ev = 8'(sweep_e[m]);
      chk("sweep_gray", out_gray, {8'd0, ev, 8'd0, ev});
    end
    tick();

    in_pixels = {24'h0, 24'h010101, 24'h808080, 24'hFFFFFF};
    mode = 2'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("sat_valid", s_out_valid, 1);
    chk("sat_gray", s_out_gray, {8'd0, 8'd2, 8'd192, 8'd255});
    tick();

    sent = 0;
    blocked = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (sent < 8);
      in_pixels = {$urandom(), $urandom(), $urandom()};
      mode      = 2'($urandom_range(0, 3));
      out_ready = (bp_pat[c % 4] != 0);
      if (in_valid && in_ready) sent++;
      if (in_valid && !in_ready) blocked++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_sent", sent, 8);
    chk("bp_in_ready_low", blocked > 0, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    nl = 0;
    nd = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid  = (c < 9);
      in_pixels = {$urandom(), $urandom(), $urandom()};
      if (out_valid && out_ready && out_last) nl++;
      if (line_done) nd++;
      tick();
    end
    chk("line_last_count", nl, 2);
    chk("line_done_count", nd, 2);

    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 6);
      tick();
    end
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    k = 0;
    idx = 0;
    nl = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4);
      if (out_valid && out_ready) begin
        k++;
        if (out_last) begin
          nl++;
          idx = k;
        end
      end
      tick();
    end
    chk("post_rst_last_count", nl, 1);
    chk("post_rst_last_idx", idx, 4);

    for (int c = 0; c < 400; c++) begin
      rst       = (c == 200);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mode      = 2'($urandom_range(0, 3));
      in_pixels = {$urandom(), $urandom(), $urandom()};
      if (c % 50 == 7) in_pixels = '1;
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
